// File: rtl/nw_vc_input_tracker.sv
// nw_vc_input_tracker: per-VC occupancy, packet framing state and credit return
// at a router input port, with sticky flags for link-protocol violations.
module nw_vc_input_tracker #(
    parameter  int num_vcs   = 4,
    parameter  int buf_depth = 4,
    localparam int cnt_w     = $clog2(buf_depth + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [num_vcs-1:0] in_vc,
    input  logic               in_head,
    input  logic               in_tail,
    input  logic               deq_valid,
    input  logic [num_vcs-1:0] deq_vc,
    output logic               credit_valid,
    output logic [num_vcs-1:0] credit_vc,
    output logic [num_vcs-1:0] vc_empty,
    output logic [num_vcs-1:0] vc_active,
    output logic               err_overflow,
    output logic               err_underflow,
    output logic               err_proto
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} pkt_state_e;

    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(buf_depth);
    localparam logic [cnt_w-1:0] one_cnt  = cnt_w'(1);

    logic [cnt_w-1:0]   count [num_vcs];
    pkt_state_e         state [num_vcs];
    logic               in_onehot, deq_onehot;
    logic [num_vcs-1:0] arr, dep, ovf_v, unf_v, proto_v;
    logic               deq_legal, bad_vc;

    assign in_onehot  = $onehot(in_vc);
    assign deq_onehot = $onehot(deq_vc);

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        arr     = '0;
        dep     = '0;
        ovf_v   = '0;
        unf_v   = '0;
        proto_v = '0;
        if (in_valid && in_onehot)   arr = in_vc;
        if (deq_valid && deq_onehot) dep = deq_vc;
        for (int v = 0; v < num_vcs; v++) begin
            ovf_v[v]   = arr[v] && !dep[v] && (count[v] == full_cnt);
            unf_v[v]   = dep[v] && !arr[v] && (count[v] == '0);
            proto_v[v] = arr[v] && ((state[v] == IDLE) ? !in_head : in_head);
        end
    end

    // A same-cycle arrival makes a dequeue from an empty VC a legal cut-through.
    assign deq_legal = |(dep & ~unf_v);
    assign bad_vc    = (in_valid && !in_onehot) || (deq_valid && !deq_onehot);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: per-VC state lives in flops, not a RAM, so every entry is cleared in reset.
            for (int v = 0; v < num_vcs; v++) begin
                count[v] <= '0;
                state[v] <= IDLE;
            end
        end else begin
            for (int v = 0; v < num_vcs; v++) begin
                // NOTE: sequential state uses non-blocking assignments only.
                if (arr[v] && !dep[v] && !ovf_v[v])
                    count[v] <= count[v] + one_cnt;
                else if (dep[v] && !arr[v] && !unf_v[v])
                    count[v] <= count[v] - one_cnt;

                if (arr[v]) begin
                    case (state[v])
                        IDLE:    if (in_head && !in_tail) state[v] <= ACTIVE;
                        ACTIVE:  if (!in_head && in_tail) state[v] <= IDLE;
                        default: state[v] <= IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_valid  <= 1'b0;
            credit_vc     <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            err_proto     <= 1'b0;
        end else begin
            credit_valid  <= deq_legal;
            credit_vc     <= deq_legal ? deq_vc : '0;
            err_overflow  <= err_overflow  || (|ovf_v);
            err_underflow <= err_underflow || (|unf_v);
            err_proto     <= err_proto     || (|proto_v) || bad_vc;
        end
    end

    // Status vectors decode registered state only, never the live inputs.
    always_comb begin
        vc_empty  = '0;
        vc_active = '0;
        for (int v = 0; v < num_vcs; v++) begin
            vc_empty[v]  = (count[v] == '0);
            vc_active[v] = (state[v] == ACTIVE);
        end
    end

endmodule
